mem_arbiter: RTL and testbench

Two-requester arbiter that shares a single external 16-bit memory port between the core's instruction bus (prefetch) and data bus (load/store). It sits directly outside the core, taking the `instr_m_*` and `data_m_*` master buses and producing one `q_m_*` master bus toward the memory/IO system. At most one transaction is outstanding at a time, and the grant is held until that transaction is acknowledged.

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter sharing one 16-bit memory port between instr and data buses
//
// Purpose: grants the single q_m_* master bus to either the prefetch (instr_m_*)
// or load/store (data_m_*) requester, one outstanding transaction at a time.
// The grant is held until q_m_ack or until the granted requester abandons.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   instr_m_*           - instruction requester: addr, access in; ack, data_in out
//   data_m_*, d_io      - data requester: addr, data_out, access, wr_en, bytesel, io in;
//                         ack, data_in out
//   q_m_*               - shared master bus: addr, data_out, access, wr_en, bytesel, io out;
//                         data_in, ack in
//   q_m_grant_data      - current grant belongs to the data requester
module mem_arbiter #(
  parameter int data_priority = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        d_io,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  input  logic [15:0] q_m_data_in,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_m_io,
  output logic        q_m_grant_data
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SERVE_INSTR = 2'd1,
    SERVE_DATA  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;  // 0 = instr, 1 = data

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == SERVE_DATA)
        last_grant <= 1'b1;
      else if (state == IDLE && state_next == SERVE_INSTR)
        last_grant <= 1'b0;
    end
  end

  always_comb begin
    state_next      = state;
    q_m_addr        = '0;
    q_m_data_out    = '0;
    q_m_access      = 1'b0;
    q_m_wr_en       = 1'b0;
    q_m_bytesel     = 2'b00;
    q_m_io          = 1'b0;
    q_m_grant_data  = 1'b0;
    instr_m_ack     = 1'b0;
    data_m_ack      = 1'b0;

    case (state)
      IDLE: begin
        // Ties: fixed data priority, or alternate away from the last winner.
        if (instr_m_access && data_m_access) begin
          if (data_priority != 0 || !last_grant)
            state_next = SERVE_DATA;
          else
            state_next = SERVE_INSTR;
        end else if (data_m_access) begin
          state_next = SERVE_DATA;
        end else if (instr_m_access) begin
          state_next = SERVE_INSTR;
        end
      end

      SERVE_INSTR: begin
        q_m_addr    = instr_m_addr;
        q_m_access  = instr_m_access;
        q_m_bytesel = 2'b11;
        instr_m_ack = q_m_ack;
        if (q_m_ack || !instr_m_access)
          state_next = IDLE;
      end

      SERVE_DATA: begin
        q_m_addr       = data_m_addr;
        q_m_data_out   = data_m_data_out;
        q_m_access     = data_m_access;
        q_m_wr_en      = data_m_wr_en;
        q_m_bytesel    = data_m_bytesel;
        q_m_io         = d_io;
        q_m_grant_data = 1'b1;
        data_m_ack     = q_m_ack;
        if (q_m_ack || !data_m_access)
          state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // Read data is only meaningful while the matching ack is high.
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (both priority modes)
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] instr_m_addr;
  logic        instr_m_access;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        d_io;
  logic [15:0] q_m_data_in;
  logic        q_m_ack;

  // outputs of the data-priority instance
  logic        instr_m_ack_p1, data_m_ack_p1;
  logic [15:0] instr_m_data_in_p1, data_m_data_in_p1;
  logic [19:1] q_m_addr_p1;
  logic [15:0] q_m_data_out_p1;
  logic        q_m_access_p1, q_m_wr_en_p1, q_m_io_p1, q_m_grant_data_p1;
  logic [1:0]  q_m_bytesel_p1;

  // outputs of the round-robin instance
  logic        instr_m_ack_p0, data_m_ack_p0;
  logic [15:0] instr_m_data_in_p0, data_m_data_in_p0;
  logic [19:1] q_m_addr_p0;
  logic [15:0] q_m_data_out_p0;
  logic        q_m_access_p0, q_m_wr_en_p0, q_m_io_p0, q_m_grant_data_p0;
  logic [1:0]  q_m_bytesel_p0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.data_priority(1)) u_dut_p1 (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack_p1), .instr_m_data_in(instr_m_data_in_p1),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .d_io(d_io),
    .data_m_ack(data_m_ack_p1), .data_m_data_in(data_m_data_in_p1),
    .q_m_addr(q_m_addr_p1), .q_m_data_out(q_m_data_out_p1),
    .q_m_data_in(q_m_data_in), .q_m_access(q_m_access_p1),
    .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en_p1),
    .q_m_bytesel(q_m_bytesel_p1), .q_m_io(q_m_io_p1),
    .q_m_grant_data(q_m_grant_data_p1)
  );

  mem_arbiter #(.data_priority(0)) u_dut_p0 (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack_p0), .instr_m_data_in(instr_m_data_in_p0),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .d_io(d_io),
    .data_m_ack(data_m_ack_p0), .data_m_data_in(data_m_data_in_p0),
    .q_m_addr(q_m_addr_p0), .q_m_data_out(q_m_data_out_p0),
    .q_m_data_in(q_m_data_in), .q_m_access(q_m_access_p0),
    .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en_p0),
    .q_m_bytesel(q_m_bytesel_p0), .q_m_io(q_m_io_p0),
    .q_m_grant_data(q_m_grant_data_p0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_m_access = 1'b1;
    data_m_access = 1'b1;
    q_m_ack = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({q_m_addr_p1, q_m_data_out_p1, q_m_access_p1, q_m_wr_en_p1, q_m_bytesel_p1,
         q_m_io_p1, q_m_grant_data_p1, instr_m_ack_p1, data_m_ack_p1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs_p1: got addr=%h dout=%h acc=%b ack i/d=%b%b, required all 0",
               q_m_addr_p1, q_m_data_out_p1, q_m_access_p1, instr_m_ack_p1, data_m_ack_p1);
    end
    n_checks++;
    if ({q_m_addr_p0, q_m_access_p0, q_m_grant_data_p0, instr_m_ack_p0, data_m_ack_p0} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs_p0: got addr=%h acc=%b gnt=%b ack i/d=%b%b, required all 0",
               q_m_addr_p0, q_m_access_p0, q_m_grant_data_p0, instr_m_ack_p0, data_m_ack_p0);
    end
    q_m_ack = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({q_m_access_p1, q_m_grant_data_p1, q_m_access_p0, q_m_grant_data_p0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got acc/gnt p1=%b%b p0=%b%b, required 0000",
               q_m_access_p1, q_m_grant_data_p1, q_m_access_p0, q_m_grant_data_p0);
    end
    tick();
    n_checks++;
    if ({q_m_access_p1, q_m_grant_data_p1, q_m_access_p0, q_m_grant_data_p0} !== 4'b1111) begin
      n_fail++;
      $display("FAIL first_grant_data: got acc/gnt p1=%b%b p0=%b%b, required 1111",
               q_m_access_p1, q_m_grant_data_p1, q_m_access_p0, q_m_grant_data_p0);
    end
    q_m_ack = 1'b1;
    #1;
    n_checks++;
    if ({data_m_ack_p1, instr_m_ack_p1, data_m_ack_p0, instr_m_ack_p0} !== 4'b1010) begin
      n_fail++;
      $display("FAIL first_ack: got d/i p1=%b%b p0=%b%b, required 1010",
               data_m_ack_p1, instr_m_ack_p1, data_m_ack_p0, instr_m_ack_p0);
    end
    instr_m_access = 1'b0;
    data_m_access = 1'b0;
    tick();
    q_m_ack = 1'b0;
  endtask

  task automatic test_instr_fetch();
    instr_m_addr = 19'h12345;
    instr_m_access = 1'b1;
    tick();
    n_checks++;
    if ({q_m_addr_p1, q_m_bytesel_p1, q_m_wr_en_p1, q_m_access_p1, q_m_io_p1, q_m_grant_data_p1}
        !== {19'h12345, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL instr_bus: got addr=%h bsel=%b wr=%b acc=%b io=%b gnt=%b, required 12345 11 0 1 0 0",
               q_m_addr_p1, q_m_bytesel_p1, q_m_wr_en_p1, q_m_access_p1, q_m_io_p1, q_m_grant_data_p1);
    end
    tick();
    n_checks++;
    if ({instr_m_ack_p1, q_m_access_p1} !== 2'b01) begin
      n_fail++;
      $display("FAIL instr_wait: got ack=%b acc=%b, required ack=0 acc=1", instr_m_ack_p1, q_m_access_p1);
    end
    q_m_data_in = 16'hBEEF;
    q_m_ack = 1'b1;
    #1;
    n_checks++;
    if ({instr_m_ack_p1, instr_m_data_in_p1, data_m_ack_p1} !== {1'b1, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL instr_ack: got iack=%b data=%h dack=%b, required 1 beef 0",
               instr_m_ack_p1, instr_m_data_in_p1, data_m_ack_p1);
    end
    tick();
    instr_m_access = 1'b0;
    q_m_ack = 1'b0;
    #1;
    n_checks++;
    if ({q_m_access_p1, instr_m_ack_p1} !== 2'b00) begin
      n_fail++;
      $display("FAIL instr_bubble: got acc=%b ack=%b, required 00", q_m_access_p1, instr_m_ack_p1);
    end
    tick();
  endtask

  task automatic test_data_io_write();
    data_m_addr = 19'h00040;
    data_m_data_out = 16'h00A5;
    data_m_wr_en = 1'b1;
    data_m_bytesel = 2'b01;
    d_io = 1'b1;
    data_m_access = 1'b1;
    tick();
    n_checks++;
    if ({q_m_addr_p1, q_m_data_out_p1, q_m_wr_en_p1, q_m_bytesel_p1, q_m_io_p1, q_m_access_p1, q_m_grant_data_p1}
        !== {19'h00040, 16'h00A5, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL data_bus: got addr=%h dout=%h wr=%b bsel=%b io=%b acc=%b gnt=%b, required 00040 00a5 1 01 1 1 1",
               q_m_addr_p1, q_m_data_out_p1, q_m_wr_en_p1, q_m_bytesel_p1, q_m_io_p1, q_m_access_p1, q_m_grant_data_p1);
    end
    q_m_ack = 1'b1;
    #1;
    n_checks++;
    if ({data_m_ack_p1, instr_m_ack_p1} !== 2'b10) begin
      n_fail++;
      $display("FAIL data_ack: got d/i=%b%b, required 10", data_m_ack_p1, instr_m_ack_p1);
    end
    // Access and ack both still high into the bubble cycle: nothing may be forwarded.
    tick();
    n_checks++;
    if ({q_m_access_p1, data_m_ack_p1, q_m_grant_data_p1, q_m_io_p1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL data_bubble: got acc=%b ack=%b gnt=%b io=%b, required 0000",
               q_m_access_p1, data_m_ack_p1, q_m_grant_data_p1, q_m_io_p1);
    end
    data_m_access = 1'b0;
    q_m_ack = 1'b0;
    tick();
    n_checks++;
    if (q_m_access_p1 !== 1'b0) begin
      n_fail++;
      $display("FAIL data_no_regrant: got acc=%b, required 0", q_m_access_p1);
    end
    d_io = 1'b0;
    data_m_wr_en = 1'b0;
  endtask

  task automatic test_abandon();
    instr_m_access = 1'b1;
    tick();
    n_checks++;
    if ({q_m_access_p1, q_m_grant_data_p1} !== 2'b10) begin
      n_fail++;
      $display("FAIL abandon_grant: got acc=%b gnt=%b, required 10", q_m_access_p1, q_m_grant_data_p1);
    end
    instr_m_access = 1'b0;
    tick();
    q_m_ack = 1'b1;
    #1;
    n_checks++;
    if ({instr_m_ack_p1, data_m_ack_p1, q_m_access_p1} !== 3'b000) begin
      n_fail++;
      $display("FAIL abandon_idle: got iack=%b dack=%b acc=%b, required 000",
               instr_m_ack_p1, data_m_ack_p1, q_m_access_p1);
    end
    q_m_ack = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_p0;
    logic [3:0] exp_p1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q_m_ack = 1'b1;
    instr_m_access = 1'b1;
    data_m_access = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      // {access, grant_data, instr_ack, data_ack}
      if (k % 2 == 0) begin
        exp_p0 = 4'b0000;
        exp_p1 = 4'b0000;
      end else if (k % 4 == 1) begin
        exp_p0 = 4'b1101;
        exp_p1 = 4'b1101;
      end else begin
        exp_p0 = 4'b1010;
        exp_p1 = 4'b1101;
      end
      n_checks++;
      if ({q_m_access_p0, q_m_grant_data_p0, instr_m_ack_p0, data_m_ack_p0} !== exp_p0) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got %b, required %b", k,
                 {q_m_access_p0, q_m_grant_data_p0, instr_m_ack_p0, data_m_ack_p0}, exp_p0);
      end
      n_checks++;
      if ({q_m_access_p1, q_m_grant_data_p1, instr_m_ack_p1, data_m_ack_p1} !== exp_p1) begin
        n_fail++;
        $display("FAIL prio_cycle%0d: got %b, required %b", k,
                 {q_m_access_p1, q_m_grant_data_p1, instr_m_ack_p1, data_m_ack_p1}, exp_p1);
      end
    end
    instr_m_access = 1'b0;
    data_m_access = 1'b0;
    q_m_ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    data_m_addr = 19'h7ABCD;
    data_m_access = 1'b1;
    tick();
    n_checks++;
    if ({q_m_access_p1, q_m_grant_data_p1, q_m_addr_p1} !== {1'b1, 1'b1, 19'h7ABCD}) begin
      n_fail++;
      $display("FAIL mid_grant: got acc=%b gnt=%b addr=%h, required 1 1 7abcd",
               q_m_access_p1, q_m_grant_data_p1, q_m_addr_p1);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({q_m_access_p1, q_m_grant_data_p1, q_m_addr_p1, q_m_access_p0} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: got acc=%b gnt=%b addr=%h acc_p0=%b, required all 0",
               q_m_access_p1, q_m_grant_data_p1, q_m_addr_p1, q_m_access_p0);
    end
    q_m_ack = 1'b1;
    #1;
    n_checks++;
    if ({data_m_ack_p1, data_m_ack_p0, instr_m_ack_p1, instr_m_ack_p0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_late_ack: got dack p1/p0=%b%b iack=%b%b, required 0000",
               data_m_ack_p1, data_m_ack_p0, instr_m_ack_p1, instr_m_ack_p0);
    end
    data_m_access = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({q_m_access_p1, data_m_ack_p1} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_after_release: got acc=%b dack=%b, required 00", q_m_access_p1, data_m_ack_p1);
    end
    q_m_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instr_m_addr = '0;
    instr_m_access = 1'b0;
    data_m_addr = '0;
    data_m_data_out = '0;
    data_m_access = 1'b0;
    data_m_wr_en = 1'b0;
    data_m_bytesel = 2'b00;
    d_io = 1'b0;
    q_m_data_in = '0;
    q_m_ack = 1'b0;
    test_reset();
    test_instr_fetch();
    test_data_io_write();
    test_abandon();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
